// File: rtl/string_hw_pkg.sv
// Shared definitions for the String HW accelerator helper blocks.
package string_hw_pkg;

  localparam int DEFAULT_MAX_WORDS = 8;
  localparam int BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } copy_state_t;

endpackage

// File: rtl/string_copy_master.sv
// Avalon-MM master that copies a block of 32-bit words from memory into the
// String HW register window, one read then one write per word.
module string_copy_master
  import string_hw_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int CNT_BITS  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_base,
  input  logic [31:0]         dst_base,
  input  logic [CNT_BITS-1:0] word_count,
  output logic                busy,
  output logic                done,
  output logic [31:0]         avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic [31:0]         avm_readdata,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid
);

  localparam logic [CNT_BITS-1:0] MAX_XFER = CNT_BITS'(2 * MAX_WORDS);

  // Clamp a requested count to StringA plus StringB.
  function automatic logic [CNT_BITS-1:0] sat_count(input logic [CNT_BITS-1:0] n);
    return (n > MAX_XFER) ? MAX_XFER : n;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [CNT_BITS-1:0] idx);
    return base + (32'(idx) * 32'(BYTES_PER_WORD));
  endfunction

  copy_state_t         state, state_nxt;
  logic [31:0]         src_q;
  logic [31:0]         dst_q;
  logic [31:0]         data_q;
  logic [CNT_BITS-1:0] remaining;
  logic [CNT_BITS-1:0] index;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (sat_count(word_count) == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          state_nxt = (remaining == CNT_BITS'(1)) ? DONE : RD_REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      remaining <= '0;
      index     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_q     <= src_base & ~32'h3;
            dst_q     <= dst_base & ~32'h3;
            remaining <= sat_count(word_count);
            index     <= '0;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            data_q <= avm_readdata;
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            index     <= index + CNT_BITS'(1);
            remaining <= remaining - CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so a stalled request holds steady.
  always_comb begin
    busy           = (state != IDLE);
    done           = (state == DONE);
    avm_read       = (state == RD_REQ);
    avm_write      = (state == WR_REQ);
    avm_writedata  = data_q;
    avm_byteenable = 4'hF;
    case (state)
      RD_REQ:  avm_address = word_addr(src_q, index);
      WR_REQ:  avm_address = word_addr(dst_q, index);
      default: avm_address = '0;
    endcase
  end

endmodule

// File: tb/tb_string_copy_master.sv
// Scoreboard bench for string_copy_master with a behavioural Avalon slave.
module tb_string_copy_master;

  localparam int MAXW = 8;
  localparam int CB   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   src_base = '0;
  logic [31:0]   dst_base = '0;
  logic [CB-1:0] word_count = '0;
  logic          busy, done;
  logic [31:0]   avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
  logic          avm_readdatavalid = 1'b0;

  string_copy_master #(.MAX_WORDS(MAXW), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .word_count(word_count),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       wr_exp_q[$];
  logic [31:0] rd_exp_q[$];
  logic [31:0] mem [logic [31:0]];

  int ws = 0;
  int lat = 1;
  bit inject = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the words a command must move, in bus order.
  task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    int k;
    logic [31:0] sa, da;
    xfer_t x;
    k  = (n > 2 * MAXW) ? 2 * MAXW : n;
    sa = s & ~32'h3;
    da = d & ~32'h3;
    for (int i = 0; i < k; i++) begin
      rd_exp_q.push_back(sa + 32'(4 * i));
      x.addr = da + 32'(4 * i);
      x.data = mem_word(sa + 32'(4 * i));
      wr_exp_q.push_back(x);
    end
  endtask

  function automatic int exp_cycles(input int n, input int w, input int l);
    int k;
    k = (n > 2 * MAXW) ? 2 * MAXW : n;
    if (k == 0) return 1;
    return 1 + k * (3 + 2 * w + (l - 1));
  endfunction

  // Slave and monitor: drives waitrequest/readdata, checks every accepted request.
  int          stall_cnt = 0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    xfer_t x;
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (reset) begin
      stall_cnt       = 0;
      lat_cnt         = 0;
      prev_stall      = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem_word(pend_addr);
        end
      end
      if (avm_read || avm_write) begin
        check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
        check("byteenable", 32'(avm_byteenable), 32'hF);
        if (prev_stall) begin
          check("stall_address", avm_address, prev_addr);
          check("stall_read", 32'(avm_read), 32'(prev_rd));
          check("stall_write", 32'(avm_write), 32'(prev_wr));
          if (prev_wr) check("stall_writedata", avm_writedata, prev_data);
        end
        if (inject && avm_read && !avm_readdatavalid) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = 32'hDEAD_BEEF;
        end
        if (stall_cnt < ws) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
          if (avm_read) begin
            if (rd_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_read: got address %h expected no read", avm_address);
            end else begin
              check("read_address", avm_address, rd_exp_q.pop_front());
            end
            pend_addr = avm_address;
            lat_cnt   = lat;
          end else begin
            if (wr_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got address %h expected no write", avm_address);
            end else begin
              x = wr_exp_q.pop_front();
              check("write_address", avm_address, x.addr);
              check("write_data", avm_writedata, x.data);
            end
          end
        end
        prev_stall = avm_waitrequest;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
        prev_rd    = avm_read;
        prev_wr    = avm_write;
      end else begin
        avm_waitrequest = 1'b0;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_base   = s;
    dst_base   = d;
    word_count = CB'(n);
    start      = 1'b1;
  endtask

  // Counts cycles from the one after the caller's last negedge up to done.
  task automatic wait_done(input string name, input int exp_k, input bit drop_start,
                           input bit exp_read, input bit chk_empty);
    int k;
    bit seen, busy_ok;
    k = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (drop_start) start = 1'b0;
        check({name, "_busy_first"}, 32'(busy), 32'd1);
        if (exp_read) check({name, "_read_first"}, 32'(avm_read), 32'd1);
      end
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
    end
    check({name, "_done_cycle"}, 32'(k), 32'(exp_k));
    check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    if (chk_empty) begin
      check({name, "_reads_left"}, 32'(rd_exp_q.size()), 32'd0);
      check({name, "_writes_left"}, 32'(wr_exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, d;
    int n, wr_starts, guard;
    bit prev_w, quiet;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_read", 32'(avm_read), 32'd0);
    check("reset_write", 32'(avm_write), 32'd0);
    check("reset_address", avm_address, 32'd0);
    check("reset_writedata", avm_writedata, 32'd0);
    check("reset_byteenable", 32'(avm_byteenable), 32'hF);
    reset = 1'b0;

    mem[32'h1000] = 32'h6162_6364;
    mem[32'h1004] = 32'h6566_6768;
    mem[32'h1008] = 32'h0000_0000;

    expect_copy(32'h1000, 32'h2004, 3);
    issue(32'h1000, 32'h2004, 3);
    wait_done("basic", 10, 1'b1, 1'b1, 1'b1);

    ws = 2;
    expect_copy(32'h1000, 32'h2004, 3);
    issue(32'h1000, 32'h2004, 3);
    wait_done("backpressure", 22, 1'b1, 1'b1, 1'b1);
    ws = 0;

    lat = 4; inject = 1'b1;
    expect_copy(32'h1000, 32'h2004, 3);
    issue(32'h1000, 32'h2004, 3);
    wait_done("latency", 19, 1'b1, 1'b1, 1'b1);
    lat = 1; inject = 1'b0;

    issue(32'h1000, 32'h2004, 0);
    wait_done("zero_count", 1, 1'b1, 1'b0, 1'b1);

    expect_copy(32'h3000, 32'h4000, 31);
    issue(32'h3000, 32'h4000, 31);
    wait_done("saturate", exp_cycles(31, 0, 1), 1'b1, 1'b1, 1'b1);

    expect_copy(32'h1003, 32'h5002, 2);
    issue(32'h1003, 32'h5002, 2);
    wait_done("unaligned", 7, 1'b1, 1'b1, 1'b1);

    // Command collision: start stays high with a new command throughout.
    expect_copy(32'h1000, 32'h2004, 3);
    expect_copy(32'h6000, 32'h7000, 2);
    issue(32'h1000, 32'h2004, 3);
    @(negedge clk);
    check("collide_busy", 32'(busy), 32'd1);
    src_base = 32'h6000; dst_base = 32'h7000; word_count = CB'(2);
    wait_done("collide_first", 9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("collide_second_busy", 32'(busy), 32'd1);
    check("collide_second_read", 32'(avm_read), 32'd1);
    wait_done("collide_second", 6, 1'b0, 1'b0, 1'b1);

    // Reset while the second write is stalled.
    ws = 2;
    expect_copy(32'h8000, 32'h9000, 4);
    while (rd_exp_q.size() > 2) void'(rd_exp_q.pop_back());
    while (wr_exp_q.size() > 1) void'(wr_exp_q.pop_back());
    issue(32'h8000, 32'h9000, 4);
    @(negedge clk);
    start = 1'b0;
    wr_starts = 0; prev_w = 1'b0; guard = 0;
    while (wr_starts < 2 && guard < 200) begin
      if (avm_write && !prev_w) wr_starts++;
      prev_w = avm_write;
      if (wr_starts < 2) begin
        @(negedge clk);
        guard++;
      end
    end
    check("reset_reached_second_write", 32'(wr_starts), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_write", 32'(avm_write), 32'd0);
    check("midreset_read", 32'(avm_read), 32'd0);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || avm_read || avm_write || busy) quiet = 1'b0;
    end
    check("midreset_quiet", 32'(quiet), 32'd1);
    check("midreset_reads_left", 32'(rd_exp_q.size()), 32'd0);
    check("midreset_writes_left", 32'(wr_exp_q.size()), 32'd0);
    ws = 0;
    expect_copy(32'h8000, 32'h9000, 4);
    issue(32'h8000, 32'h9000, 4);
    wait_done("after_reset", 13, 1'b1, 1'b1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      s   = $urandom;
      d   = $urandom;
      n   = $urandom_range(0, 20);
      ws  = $urandom_range(0, 2);
      lat = $urandom_range(1, 3);
      expect_copy(s, d, n);
      issue(s, d, n);
      wait_done("random", exp_cycles(n, ws, lat), 1'b1, n != 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
